i2s_sample_stream: RTL and testbench

Oversampled I2S receiver that takes the WM8731 ADC serial pins (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) into the CLOCK_50 domain. It deserialises the left-channel word and buffers samples in a small FIFO. Samples are presented on a valid/ready stream that feeds `snr_calculator.audio_input`, replacing free-running `data` with `audio_input_valid` tied high. The block also provides sticky overrun and short-frame flags for debug LEDs.

---
 rtl/i2s_sample_stream.sv | 215 +++++++++++++++++++++
 tb/tb_i2s_sample_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_stream.sv
// i2s_sample_stream: oversampled I2S left-channel receiver with a small sample FIFO.
// The serial pins are synchronised into the clk domain and sampled on detected BCLK rises.
// Completed words are presented on a valid/ready stream, with sticky overrun and short-frame flags.
module i2s_sample_stream #(
  parameter int unsigned W          = 16,
  parameter int unsigned DATA_DELAY = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bclk,
  input  logic                     adclrck,
  input  logic                     adcdat,
  output logic [W-1:0]             sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overrun,
  output logic                     short_frame,
  input  logic                     clear_flags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned SW = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;

  typedef enum logic [1:0] {
    WAIT_LRC = 2'd0,
    SKIP     = 2'd1,
    SHIFT    = 2'd2
  } state_t;

  // First state after an LRCK fall: skip delay bits, or shift straight away in left-justified mode
  localparam state_t FIRST = (DATA_DELAY > 0) ? SKIP : SHIFT;

  logic [2:0]    bclk_sync;
  logic [2:0]    lrc_sync;
  logic [1:0]    dat_sync;
  logic          bclk_rise;
  logic          lrc_fall;
  logic          lrc_rise;
  logic          dat;

  state_t        state;
  state_t        state_next;

  logic [CW-1:0] bit_cnt;
  logic [SW-1:0] skip_cnt;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  push_data;
  logic          last_bit;
  logic          skip_done;

  logic          frame_start;
  logic          abort;
  logic          skip_inc;
  logic          shift_en;
  logic          push;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_next;
  logic [PW-1:0] rptr_next;
  logic [PW-1:0] count;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  // Two-flop synchronisers; bclk and adclrck carry a third stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= 3'b000;
      lrc_sync  <= 3'b000;
      dat_sync  <= 2'b00;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      lrc_sync  <= {lrc_sync[1:0], adclrck};
      dat_sync  <= {dat_sync[0], adcdat};
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lrc_fall  = ~lrc_sync[1] & lrc_sync[2];
  assign lrc_rise  = lrc_sync[1] & ~lrc_sync[2];
  assign dat       = dat_sync[1];

  assign last_bit  = (bit_cnt == CW'(W - 1));
  assign skip_done = (skip_cnt == SW'(DATA_DELAY - 1));
  assign push_data = {shift_reg[W-2:0], dat};

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LRC;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: LRCK edges restart or abandon a frame ahead of any BCLK activity
  always_comb begin
    state_next = state;
    case (state)
      WAIT_LRC: begin
        if (lrc_fall) state_next = FIRST;
      end
      SKIP: begin
        if (lrc_fall)                    state_next = FIRST;
        else if (lrc_rise)               state_next = WAIT_LRC;
        else if (bclk_rise && skip_done) state_next = SHIFT;
      end
      SHIFT: begin
        if (lrc_fall)                   state_next = FIRST;
        else if (lrc_rise)              state_next = WAIT_LRC;
        else if (bclk_rise && last_bit) state_next = WAIT_LRC;
      end
      default: state_next = WAIT_LRC;
    endcase
  end

  // FSM outputs: datapath strobes derived from state and synchronised edges
  always_comb begin
    frame_start = 1'b0;
    abort       = 1'b0;
    skip_inc    = 1'b0;
    shift_en    = 1'b0;
    push        = 1'b0;
    case (state)
      WAIT_LRC: begin
        frame_start = lrc_fall;
      end
      SKIP: begin
        abort       = lrc_fall | lrc_rise;
        frame_start = lrc_fall;
        skip_inc    = bclk_rise & ~abort;
      end
      SHIFT: begin
        abort       = lrc_fall | lrc_rise;
        frame_start = lrc_fall;
        shift_en    = bclk_rise & ~abort;
        push        = shift_en & last_bit;
      end
      default: begin
        frame_start = 1'b0;
      end
    endcase
  end

  // Bit/skip counters and the deserialising shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      skip_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      if (frame_start) begin
        bit_cnt  <= '0;
        skip_cnt <= '0;
      end else begin
        if (skip_inc) skip_cnt <= skip_cnt + SW'(1);
        if (shift_en) bit_cnt  <= bit_cnt + CW'(1);
      end
      if (shift_en) shift_reg <= push_data;
    end
  end

  assign count     = wptr - rptr;
  assign full      = (count == PW'(DEPTH));
  assign pop       = sample_valid & sample_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign wptr_next = wptr + PW'(push_ok);
  assign rptr_next = rptr + PW'(pop);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

  // FIFO pointers and registered stream outputs; a push into an empty FIFO bypasses to the head
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      fill         <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      fill         <= wptr_next - rptr_next;
      sample_valid <= (wptr_next != rptr_next);
      if (push_ok && (rptr_next == wptr)) begin
        sample_data <= push_data;
      end else if (wptr_next != rptr_next) begin
        sample_data <= mem[rptr_next[AW-1:0]];
      end
    end
  end

  // Sticky debug flags; a new event in the same cycle as clear_flags keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      overrun     <= drop  | (overrun & ~clear_flags);
      short_frame <= abort | (short_frame & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_i2s_sample_stream.sv
// Testbench for i2s_sample_stream: drives I2S frames into an I2S-mode and a left-justified
// instance and compares every cycle against a frame-level reference model with sample queues.
module tb_i2s_sample_stream;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        bclk = 1'b0;
  logic        adclrck = 1'b0;
  logic        adcdat = 1'b0;
  logic        sample_ready = 1'b0;
  logic        clear_flags = 1'b0;

  logic [15:0] data0, data1;
  logic        valid0, valid1;
  logic [2:0]  fill0, fill1;
  logic        ovr0, ovr1;
  logic        sf0, sf1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2s_sample_stream #(.W(16), .DATA_DELAY(1), .DEPTH(4)) u_i2s (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .adclrck(adclrck), .adcdat(adcdat),
    .sample_data(data0), .sample_valid(valid0), .sample_ready(sample_ready),
    .fill(fill0), .overrun(ovr0), .short_frame(sf0), .clear_flags(clear_flags)
  );

  i2s_sample_stream #(.W(16), .DATA_DELAY(0), .DEPTH(4)) u_lj (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .adclrck(adclrck), .adcdat(adcdat),
    .sample_data(data1), .sample_valid(valid1), .sample_ready(sample_ready),
    .fill(fill1), .overrun(ovr1), .short_frame(sf1), .clear_flags(clear_flags)
  );

  // Reference model: per instance, frame tracking plus an ideal sample queue
  int          dd [2] = '{1, 0};
  logic [15:0] mq0 [$];
  logic [15:0] mq1 [$];
  logic [15:0] pop0 [$];
  logic [15:0] pop1 [$];
  bit          m_ovr [2];
  bit          m_sf [2];
  bit          in_frame [2];
  int          kcnt [2];
  logic [15:0] word [2];
  bit          pp [2][3];
  logic [15:0] pv [2][3];
  bit          sfp [2][3];
  logic        prev_bclk, prev_lrck;
  bit          rand_mode = 0;
  bit          pop_on_push = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [15:0] qfront(input int i);
    if (qsize(i) == 0) return 16'h0;
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(mq0.pop_front());
    else        void'(mq1.pop_front());
  endtask

  task automatic qpush(input int i, input logic [15:0] v);
    if (i == 0) mq0.push_back(v);
    else        mq1.push_back(v);
  endtask

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    prev_bclk = 1'b0;
    prev_lrck = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ovr[i] = 0; m_sf[i] = 0; in_frame[i] = 0; kcnt[i] = 0; word[i] = '0;
      for (int j = 0; j < 3; j++) begin
        pp[i][j] = 0; pv[i][j] = '0; sfp[i][j] = 0;
      end
    end
  endtask

  // Advance the model across the coming posedge using the pins as currently driven
  task automatic model_update();
    bit b_r, l_f, l_r, pop;
    if (!reset_n) begin
      model_clear();
      return;
    end
    b_r = bclk & ~prev_bclk;
    l_f = ~adclrck & prev_lrck;
    l_r = adclrck & ~prev_lrck;
    prev_bclk = bclk;
    prev_lrck = adclrck;
    for (int i = 0; i < 2; i++) begin
      pp[i][2] = pp[i][1]; pv[i][2] = pv[i][1]; sfp[i][2] = sfp[i][1];
      pp[i][1] = pp[i][0]; pv[i][1] = pv[i][0]; sfp[i][1] = sfp[i][0];
      pp[i][0] = 0; sfp[i][0] = 0;
      if (l_f) begin
        if (in_frame[i]) sfp[i][0] = 1;
        in_frame[i] = 1;
        kcnt[i] = 0;
      end else if (l_r) begin
        if (in_frame[i]) sfp[i][0] = 1;
        in_frame[i] = 0;
      end else if (b_r && in_frame[i]) begin
        if (kcnt[i] >= dd[i]) word[i] = {word[i][14:0], adcdat};
        kcnt[i]++;
        if (kcnt[i] == dd[i] + 16) begin
          pp[i][0] = 1;
          pv[i][0] = word[i];
          in_frame[i] = 0;
        end
      end
      pop = (qsize(i) > 0) && sample_ready;
      if (pop) qpop(i);
      m_ovr[i] = m_ovr[i] & ~clear_flags;
      if (pp[i][2]) begin
        if (qsize(i) < 4) qpush(i, pv[i][2]);
        else m_ovr[i] = 1;
      end
      m_sf[i] = sfp[i][2] | (m_sf[i] & ~clear_flags);
    end
  endtask

  task automatic check_outputs();
    check("valid0", 32'(valid0), 32'(qsize(0) > 0));
    check("fill0",  32'(fill0),  32'(qsize(0)));
    check("ovr0",   32'(ovr0),   32'(m_ovr[0]));
    check("sf0",    32'(sf0),    32'(m_sf[0]));
    if (qsize(0) > 0) check("data0", 32'(data0), 32'(qfront(0)));
    check("valid1", 32'(valid1), 32'(qsize(1) > 0));
    check("fill1",  32'(fill1),  32'(qsize(1)));
    check("ovr1",   32'(ovr1),   32'(m_ovr[1]));
    check("sf1",    32'(sf1),    32'(m_sf[1]));
    if (qsize(1) > 0) check("data1", 32'(data1), 32'(qfront(1)));
  endtask

  // One clk cycle: finalise inputs, log accepted samples, update model, then check after the edge
  task automatic tick();
    if (rand_mode) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      clear_flags  = ($urandom_range(0, 49) == 0);
    end
    if (pop_on_push) sample_ready = pp[0][1];
    if (valid0 && sample_ready) pop0.push_back(data0);
    if (valid1 && sample_ready) pop1.push_back(data1);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_data0"},  32'(data0),  32'h0);
    check({tag, "_valid0"}, 32'(valid0), 32'h0);
    check({tag, "_fill0"},  32'(fill0),  32'h0);
    check({tag, "_ovr0"},   32'(ovr0),   32'h0);
    check({tag, "_sf0"},    32'(sf0),    32'h0);
    check({tag, "_data1"},  32'(data1),  32'h0);
    check({tag, "_valid1"}, 32'(valid1), 32'h0);
    check({tag, "_fill1"},  32'(fill1),  32'h0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 reset_checks(tag);
    model_clear();
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic bclk_cycle(input logic lr, input logic d, input int half);
    bclk = 1'b0; adclrck = lr; adcdat = d;
    repeat (half) tick();
    bclk = 1'b1;
    repeat (half) tick();
  endtask

  // Bits are sent MSB-first from the top of lb/rb, one per BCLK period
  task automatic send_frame(input logic [63:0] lb, input int nl, input logic [63:0] rb,
                            input int nr, input int half, input int rst_at);
    for (int i = 0; i < nl; i++) begin
      if (i == rst_at) async_reset("midrst");
      bclk_cycle(1'b0, lb[63-i], half);
    end
    for (int j = 0; j < nr; j++) bclk_cycle(1'b1, rb[63-j], half);
  endtask

  function automatic logic [63:0] i2s_word(input logic [15:0] w);
    return {1'b0, w, 47'd0};
  endfunction

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    tick();
  endtask

  initial begin
    logic [63:0] lb, rb;
    int nl, half;

    model_clear();
    #2 reset_n = 1'b0;
    #1 reset_checks("por");
    repeat (3) tick();
    reset_n = 1'b1;
    sample_ready = 1'b1;
    // Idle right half so the first left frame begins with a clean LRCK fall
    repeat (2) bclk_cycle(1'b1, 1'b0, 8);

    // Basic I2S capture
    pop0.delete();
    for (int f = 0; f < 3; f++) send_frame(i2s_word(16'h8001), 24, i2s_word(16'h7FFF), 24, 8, -1);
    check("basic_count", 32'(pop0.size()), 32'd3);
    foreach (pop0[i]) check("basic_data", 32'(pop0[i]), 32'h8001);

    // Left-justified word seen by both instances
    pop0.delete(); pop1.delete();
    send_frame({16'h1234, 48'd0}, 24, 64'd0, 24, 8, -1);
    check("lj_count1", 32'(pop1.size()), 32'd1);
    if (pop1.size() > 0) check("lj_data1", 32'(pop1[0]), 32'h1234);
    check("lj_count0", 32'(pop0.size()), 32'd1);
    if (pop0.size() > 0) check("lj_data0", 32'(pop0[0]), 32'h2468);

    // Backpressure and overrun
    sample_ready = 1'b0;
    for (int f = 1; f <= 6; f++) send_frame(i2s_word(16'(f)), 24, 64'd0, 24, 8, -1);
    check("bp_fill", 32'(fill0), 32'd4);
    check("bp_overrun", 32'(ovr0), 32'd1);
    pop0.delete();
    sample_ready = 1'b1;
    repeat (8) tick();
    check("bp_count", 32'(pop0.size()), 32'd4);
    foreach (pop0[i]) check("bp_order", 32'(pop0[i]), 32'(i + 1));
    check("bp_drained", 32'(fill0), 32'd0);
    pulse_clear();
    check("bp_ovr_cleared", 32'(ovr0), 32'd0);

    // Simultaneous push and pop while full
    sample_ready = 1'b0;
    for (int f = 11; f <= 14; f++) send_frame(i2s_word(16'(f)), 24, 64'd0, 24, 8, -1);
    pop_on_push = 1;
    send_frame(i2s_word(16'd15), 24, 64'd0, 24, 8, -1);
    pop_on_push = 0;
    sample_ready = 1'b0;
    check("pp_fill", 32'(fill0), 32'd4);
    check("pp_no_ovr", 32'(ovr0), 32'd0);
    pop0.delete();
    sample_ready = 1'b1;
    repeat (8) tick();
    check("pp_count", 32'(pop0.size()), 32'd4);
    foreach (pop0[i]) check("pp_order", 32'(pop0[i]), 32'(i + 12));
    pulse_clear();

    // Short frame: LRCK rises after 9 data bits
    pop0.delete();
    send_frame(i2s_word(16'hFFFF), 10, 64'd0, 24, 8, -1);
    check("sf_flag", 32'(sf0), 32'd1);
    check("sf_nopush", 32'(pop0.size()), 32'd0);
    send_frame(i2s_word(16'hABCD), 24, 64'd0, 24, 8, -1);
    check("sf_next_count", 32'(pop0.size()), 32'd1);
    if (pop0.size() > 0) check("sf_next_data", 32'(pop0[0]), 32'hABCD);
    check("sf_still_set", 32'(sf0), 32'd1);
    pulse_clear();
    check("sf_cleared", 32'(sf0), 32'd0);

    // Reset during bit 8, then a clean frame
    pop0.delete();
    send_frame(i2s_word(16'hFFFF), 24, 64'd0, 24, 8, 8);
    check("rst_ignored", 32'(pop0.size()), 32'd0);
    check("rst_no_sf", 32'(sf0), 32'd0);
    send_frame(i2s_word(16'h5A5A), 24, 64'd0, 24, 8, -1);
    check("rst_next_count", 32'(pop0.size()), 32'd1);
    if (pop0.size() > 0) check("rst_next_data", 32'(pop0[0]), 32'h5A5A);

    // Randomised frames, lengths, BCLK rates, backpressure and flag clears
    rand_mode = 1;
    for (int f = 0; f < 14; f++) begin
      lb = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      nl = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(17, 28);
      half = $urandom_range(3, 8);
      send_frame(lb, nl, rb, $urandom_range(2, 20), half, -1);
    end
    rand_mode = 0;
    sample_ready = 1'b1;
    clear_flags = 1'b0;
    repeat (8) tick();
    check("final_empty0", 32'(fill0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
